// File: rtl/wb_pkg.sv
// Shared widths and the request record carried through the long-latency result FIFO.
package wb_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_ll_fifo.sv
// Circular buffer of long-latency results; push and pop may coincide, with no bypass.
module wb_ll_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned LL_DEPTH = 2,
  localparam int unsigned CNT_W    = $clog2(LL_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  output wb_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int unsigned PTR_W = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;

  wb_req_t          mem [LL_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(LL_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_req;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/wb_write_port.sv
// Register-file write port: pipeline writeback with priority, buffered long-latency results,
// busy scoreboard. Optional WB_STARVE_GUARD_EN adds an age counter and stall_req.
module wb_write_port #(
  parameter int unsigned DATA_W       = wb_pkg::DATA_W,
  parameter int unsigned ADDR_W       = wb_pkg::ADDR_W,
`ifdef WB_STARVE_GUARD_EN
  parameter int unsigned STARVE_LIMIT = 8,
`endif
  parameter int unsigned LL_DEPTH     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wb_valid,
  input  logic [ADDR_W-1:0]             wb_rd,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic                          ll_issue,
  input  logic [ADDR_W-1:0]             ll_issue_rd,
  input  logic                          ll_valid,
  output logic                          ll_ready,
  input  logic [ADDR_W-1:0]             ll_rd,
  input  logic [DATA_W-1:0]             ll_data,
  output logic                          writeRegister,
  output logic [ADDR_W-1:0]             writeAddress,
  output logic [DATA_W-1:0]             writeData,
  output logic [wb_pkg::NUM_REGS-1:0]   busy,
`ifdef WB_STARVE_GUARD_EN
  output logic                          stall_req,
`endif
  output logic [$clog2(LL_DEPTH+1)-1:0] ll_count
);
  wb_pkg::wb_req_t            ll_req;
  wb_pkg::wb_req_t            head;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;
  logic                       wb_take;
  logic [wb_pkg::NUM_REGS-1:0] busy_next;

  assign ll_req   = '{rd: ll_rd, data: ll_data};
  assign ll_ready = reset && !full;
  assign push     = ll_valid && ll_ready;

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 2);
  logic [AGE_W-1:0] age;

  assign stall_req = (age >= AGE_W'(STARVE_LIMIT));
  assign wb_take   = wb_valid && (wb_rd != '0) && !stall_req;

  // Saturates at the limit so a long stall can never wrap back below it.
  always_ff @(posedge clk) begin
    if (!reset || pop || empty) age <= '0;
    else if (!stall_req)        age <= age + 1'b1;
  end
`else
  assign wb_take = wb_valid && (wb_rd != '0);
`endif

  assign pop = !empty && !wb_take;

  wb_ll_fifo #(.LL_DEPTH(LL_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_req (ll_req),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (ll_count)
  );

  // Clear before set so an issue to the retiring register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (pop && head.rd != '0) busy_next[head.rd] = 1'b0;
    if (ll_issue && ll_issue_rd != '0) busy_next[ll_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      writeRegister <= 1'b0;
      writeAddress  <= '0;
      writeData     <= '0;
      busy          <= '0;
    end else begin
      writeRegister <= 1'b0;
      if (wb_take) begin
        writeRegister <= 1'b1;
        writeAddress  <= wb_rd;
        writeData     <= wb_data;
      end else if (pop && head.rd != '0) begin
        writeRegister <= 1'b1;
        writeAddress  <= head.rd;
        writeData     <= head.data;
      end
      busy <= busy_next;
    end
  end

`ifndef SYNTHESIS
  a_issue_to_busy: assert property (@(posedge clk) disable iff (!reset)
    !(ll_issue && ll_issue_rd != '0 && busy[ll_issue_rd] && !(pop && head.rd == ll_issue_rd)));
  a_wb_waw: assert property (@(posedge clk) disable iff (!reset)
    !(wb_take && busy[wb_rd]));
`ifdef WB_STARVE_GUARD_EN
  a_wb_lost: assert property (@(posedge clk) disable iff (!reset)
    !(wb_valid && wb_rd != '0 && stall_req));
`endif
`endif
endmodule

// File: doc/wb_write_port.md
Name: wb_write_port

Overview:
- Writer side of the register-file write port (writeRegister/writeAddress/writeData).
- Merges two result sources onto the single write port:
  - the in-order pipeline's writeback result, with fixed priority;
  - a long-latency unit's result (mul/div/load-miss) over a valid/ready handshake, buffered in a small FIFO.
- Keeps a busy-register scoreboard so hazard logic can stall consumers of outstanding long-latency results.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 architectural registers).
- LL_DEPTH, 2, long-latency result FIFO depth (>=1).
- STARVE_LIMIT, 8, cycles a FIFO head may wait before stall_req (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-low reset.
- wb_valid  in  1  pipeline result valid this cycle.
- wb_rd  in  ADDR_W  pipeline destination register.
- wb_data  in  DATA_W  pipeline result.
- ll_issue  in  1  long-latency op issued this cycle.
- ll_issue_rd  in  ADDR_W  its destination register.
- ll_valid  in  1  long-latency result offered.
- ll_ready  out  1  FIFO can accept the result.
- ll_rd  in  ADDR_W  long-latency result destination.
- ll_data  in  DATA_W  long-latency result.
- writeRegister  out  1  register-file write enable.
- writeAddress  out  ADDR_W  register-file write address.
- writeData  out  DATA_W  register-file write data.
- busy  out  32  scoreboard, bit r = result for xr outstanding.
- ll_count  out  $clog2(LL_DEPTH+1)  FIFO occupancy.
- stall_req  out  1  present only with the optional feature.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-low. All state updates on posedge clk.
- Reset values (while reset==0 at a posedge): writeRegister=0, writeAddress=0, writeData=0, busy=0, FIFO empty, ll_count=0, stall_req=0.
- ll_ready is forced 0 while reset is low.
- Reset mid-operation discards FIFO contents and in-flight writes; busy clears.
- Output register: writeRegister/Address/Data are registered. A selection made in cycle N appears in cycle N+1 and is held for exactly one cycle.
- Per-cycle port selection:
  1. wb_valid && wb_rd!=0 → pipeline write.
  2. Else if FIFO non-empty → pop head and write it.
  3. Else writeRegister=0. writeAddress/Data hold their previous values.
- x0 handling:
  - wb_valid with wb_rd==0 is dropped and does not take the port.
  - An ll result with ll_rd==0 is accepted normally and discarded at pop; no write, no busy change.
- FIFO:
  - ll_ready = !full, from registered count.
  - Push when ll_valid && ll_ready.
  - Push and pop in the same cycle are both legal; count unchanged.
  - No bypass: minimum ll_valid→writeRegister latency is 2 cycles.
  - Order is strictly FIFO.
- Scoreboard:
  - ll_issue && ll_issue_rd!=0 sets busy[ll_issue_rd].
  - The FIFO pop that writes register r clears busy[r] in the same edge that loads the output register.
  - Simultaneous set and clear of the same bit: set wins.
  - busy[0] is always 0.
- Upstream contract:
  - No ll_issue to a register already busy.
  - No wb write to a busy register (WAW).
  - The block does not check either; a simulation assertion flags violations.
- Starvation: without the optional feature, a FIFO entry may wait indefinitely while wb_valid stays high. ll_ready stays low while the FIFO is full.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- Defined:
  - An age counter increments each cycle the FIFO is non-empty and no pop occurs; it resets on pop or when the FIFO is empty.
  - stall_req = (age >= STARVE_LIMIT), combinational from the registered age.
  - While stall_req=1, the FIFO head has priority over wb_valid. A wb write arriving during stall_req is lost, and a simulation assertion fires.
- Undefined: no stall_req port, no age counter; fixed pipeline priority.

Decomposition:
- Package wb_pkg:
  - DATA_W and ADDR_W constants.
  - typedef wb_req_t {logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data;}.
  - NUM_REGS=32.
- Sub-module wb_ll_fifo: parameterised LL_DEPTH circular buffer of wb_req_t with push/pop/full/empty/count. Arbiter, scoreboard and output register stay in the top.

Test Plan:
- Reset then wb_valid=1, rd=5, data=0xDEADBEEF at cycle 1 → writeRegister=1, writeAddress=5, writeData=0xDEADBEEF at cycle 2 only; ll_ready=1.
- ll_issue rd=7 → busy[7]=1. Then ll_valid rd=7, data=0x12 with wb idle → write x7=0x12 two cycles after ll_valid; busy[7]=0 in the same cycle.
- wb_valid continuously with rd=3, plus two ll results rd=8 and rd=9 → ll_count=2 and ll_ready=0. Third ll_valid stalls. After wb_valid drops, writes occur x8 then x9 on consecutive cycles.
- wb_valid rd=0 with FIFO holding rd=4 → FIFO entry written the next cycle. ll result rd=0 → accepted and popped, no writeRegister, busy unchanged.
- Same-cycle ll_issue rd=6 and pop of an entry for rd=6 → busy[6] stays 1. Reset asserted with 2 FIFO entries → ll_count=0, busy=0, no writes after reset release.
- With WB_STARVE_GUARD_EN and STARVE_LIMIT=8, wb_valid held high with 1 FIFO entry → stall_req rises after 8 cycles of waiting; next write is the FIFO entry, then stall_req=0.
